cpu_control_sequencer: RTL

//  Multi-cycle control FSM for the Simple-CPU datapath (PC, IR, register file, single shared memory port).
//  - Sequences each instruction through fetch, decode, execute, memory and writeback.
//  - Arbitrates the one memory port between instruction fetch and lw/sw data access.
//  - Emits the pc/ir/reg/mem write strobes; the decoder supplies the is_* flags.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/ctrl_perf_counters.sv | 34 +++
 rtl/cpu_control_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the Simple-CPU control sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERROR  = 3'd7
    } ctrl_state_t;

    localparam logic MEM_SEL_FETCH = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;

    // States that own the shared memory port.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Retired-instruction and memory-stall counters; wrap at 2^CNT_W.
module ctrl_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_we_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] retired_count_o,
    output logic [CNT_W-1:0] stall_count_o
);

    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        retired_d = retired_q + CNT_W'(pc_we_i);
        stall_d   = stall_q + CNT_W'(stall_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_count_o = retired_q;
    assign stall_count_o   = stall_q;

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM for the Simple-CPU datapath with shared memory port arbitration.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_lw,
    input  logic             is_sw,
    input  logic             is_halt,
    input  logic             is_wb,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    ctrl_state_t     state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            halted_q, halted_d;
    logic            error_q, error_d;
    logic            timeout_hit;

    // Last tolerated not-ready cycle of the current access.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_sel  = MEM_SEL_FETCH;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        to_cnt_d = (is_mem_state(state_q) && !mem_ready) ? to_cnt_q + TO_W'(1) : '0;

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                mem_sel = MEM_SEL_FETCH;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            DECODE: state_d = is_halt ? HALT : EXEC;
            EXEC:   state_d = (is_lw || is_sw) ? MEM : WB;
            MEM: begin
                mem_req = 1'b1;
                mem_sel = MEM_SEL_DATA;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            WB: begin
                reg_we  = is_wb || is_lw;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase

        halted_d = halted_q || (state_d == HALT);
        error_d  = error_q || (state_d == ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign state_o = state_q;
    assign halted  = halted_q;
    assign error   = error_q;

`ifdef PERF_COUNTERS_EN
    ctrl_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk             (clock),
        .rst_n           (reset_n),
        .pc_we_i         (pc_we),
        .stall_i         (mem_req & ~mem_ready),
        .retired_count_o (retired_count),
        .stall_count_o   (stall_count)
    );
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule
